// File: rtl/mem_bus_pkg.sv
// Shared encodings for the memory bus: arbiter state codes and requester IDs.
package mem_bus_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DRIVE   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

    typedef enum logic {
        REQ_VID = 1'b0,
        REQ_CPU = 1'b1
    } req_id_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side handshake bundle for the CPU and video ports of the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_ack;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  vid_req;
    logic [ADDR_WIDTH-1:0] vid_addr;
    logic                  vid_ack;
    logic [DATA_WIDTH-1:0] vid_rdata;

    // Requesters: issue requests, receive completions.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr,
        input  cpu_ack, cpu_rdata, vid_ack, vid_rdata
    );

    // Arbiter: accepts requests, returns completions.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr,
        output cpu_ack, cpu_rdata, vid_ack, vid_rdata
    );

    // Grant logic: only needs to see who is asking and who is completing.
    modport arb (
        input cpu_req, vid_req, cpu_ack, vid_ack
    );
endinterface

// File: rtl/mem_arb_priority.sv
// Grant decision between video and CPU with a bounded CPU starvation counter.
module mem_arb_priority
    import mem_bus_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    arb_point,
    mem_arbiter_if.arb req,
    output logic    grant_valid,
    output req_id_t grant_id
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             cpu_pend;
    logic             vid_pend;

    // A requester whose ack is showing is still holding its finished request; ignore it.
    always_comb begin
        cpu_pend    = req.cpu_req & ~req.cpu_ack;
        vid_pend    = req.vid_req & ~req.vid_ack;
        grant_valid = arb_point & (cpu_pend | vid_pend);
        grant_id    = (cpu_pend && (!vid_pend || starve_cnt == LIMIT)) ? REQ_CPU : REQ_VID;
    end

    // Count video grants made while the CPU is asking; saturates at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (arb_point) begin
            if (grant_valid && grant_id == REQ_CPU) begin
                starve_cnt <= '0;
            end else if (!req.cpu_req) begin
                starve_cnt <= '0;
            end else if (grant_valid && starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (video/CPU) arbiter for a shared single-port tri-state memory bus.
module mem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic                  vid_ack,
    output logic [DATA_WIDTH-1:0] vid_rdata,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    inout  tri   [DATA_WIDTH-1:0] bus_data,
    output logic                  bus_enable,
    output logic                  bus_oenable,
    output logic                  bus_wenable
);

    mem_arbiter_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) req_bus ();

    logic [1:0]            state;
    req_id_t               owner;
    logic                  op_we;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  cpu_ack_q;
    logic                  vid_ack_q;
    logic [DATA_WIDTH-1:0] cpu_rdata_q;
    logic [DATA_WIDTH-1:0] vid_rdata_q;
    logic                  arb_point;
    logic                  grant_valid;
    req_id_t               grant_id;

    // Flat legacy ports are bridged onto the internal requester bundle.
    assign req_bus.cpu_req   = cpu_req;
    assign req_bus.cpu_we    = cpu_we;
    assign req_bus.cpu_addr  = cpu_addr;
    assign req_bus.cpu_wdata = cpu_wdata;
    assign req_bus.vid_req   = vid_req;
    assign req_bus.vid_addr  = vid_addr;
    assign req_bus.cpu_ack   = cpu_ack_q;
    assign req_bus.cpu_rdata = cpu_rdata_q;
    assign req_bus.vid_ack   = vid_ack_q;
    assign req_bus.vid_rdata = vid_rdata_q;
    assign cpu_ack           = req_bus.cpu_ack;
    assign cpu_rdata         = req_bus.cpu_rdata;
    assign vid_ack           = req_bus.vid_ack;
    assign vid_rdata         = req_bus.vid_rdata;

    assign arb_point = (state == ST_IDLE) || (state == ST_CAPTURE);

    mem_arb_priority #(.STARVE_LIMIT(STARVE_LIMIT)) u_priority (
        .clk         (clk),
        .rst_n       (rst_n),
        .arb_point   (arb_point),
        .req         (req_bus.arb),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Access sequencer: one DRIVE cycle then one CAPTURE cycle per grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_CAPTURE: state <= grant_valid ? ST_DRIVE : ST_IDLE;
                ST_DRIVE:            state <= ST_CAPTURE;
                default:             state <= ST_IDLE;
            endcase
        end
    end

    // Latch winner, address and operation at the arbitration edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner   <= REQ_VID;
            op_we   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant_valid) begin
            owner <= grant_id;
            if (grant_id == REQ_CPU) begin
                op_we   <= req_bus.cpu_we;
                addr_q  <= req_bus.cpu_addr;
                wdata_q <= req_bus.cpu_wdata;
            end else begin
                op_we  <= 1'b0;
                addr_q <= req_bus.vid_addr;
            end
        end
    end

    // Complete the access on the edge ending DRIVE: ack the owner, capture read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_ack_q   <= 1'b0;
            vid_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
        end else begin
            cpu_ack_q <= (state == ST_DRIVE) && (owner == REQ_CPU);
            vid_ack_q <= (state == ST_DRIVE) && (owner == REQ_VID);
            if (state == ST_DRIVE && !op_we) begin
                if (owner == REQ_CPU) begin
                    cpu_rdata_q <= bus_data;
                end else begin
                    vid_rdata_q <= bus_data;
                end
            end
        end
    end

    // Bus strobes are decoded from state so reset clears them immediately.
    assign bus_addr    = addr_q;
    assign bus_enable  = (state == ST_DRIVE);
    assign bus_oenable = bus_enable & ~op_we;
    assign bus_wenable = bus_enable & op_we;
    assign bus_data    = bus_wenable ? wdata_q : 'z;

endmodule
